// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg
// Shared definitions for the 4x4 matrix keypad scanner:
//   - FSM state encodings KP_SCAN, KP_DEBOUNCE, KP_HELD (2 bits)
//   - KP_COL_IDLE, the column drive pattern after reset (column 0 driven)
//   - kp_key_t, a captured key position {row, col}
//   - helpers for picking the lowest active-low row and building the
//     active-low one-hot column drive pattern
package keypad_scanner_pkg;

  localparam logic [1:0] KP_SCAN     = 2'd0;
  localparam logic [1:0] KP_DEBOUNCE = 2'd1;
  localparam logic [1:0] KP_HELD     = 2'd2;

  localparam logic [3:0] KP_COL_IDLE = 4'b1110;

  // Packed so it can be assigned straight onto the 4-bit key code,
  // which is defined as 4*row + col.
  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } kp_key_t;

  // Index of the lowest row reading 0. Scanning from the top down means
  // the last assignment wins, so row 0 has priority when several are low.
  function automatic logic [1:0] kp_lowest_low(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = i[1:0];
    end
    return idx;
  endfunction

  function automatic logic [3:0] kp_col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for asynchronous level inputs. Both stages reset to
// all-ones, which matches idle pulled-up keypad rows.
// Ports:
//   clk  in          system clock
//   rst  in          synchronous active-high reset
//   d    in  WIDTH   asynchronous input
//   q    out WIDTH   synchronized output, two cycles behind d
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad: drives one column at a time, reads
// the synchronized rows back, debounces the first key found and reports it
// as a 4-bit code (4*row + col) with a one-cycle valid strobe. The key is
// then tracked until a debounced release before scanning resumes.
//
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-strobe a held key
// every REPEAT_CNT cycles. Without it there is exactly one strobe per press.
//
// Parameters:
//   SCAN_DIV      cycles each column stays driven (>= 4)
//   DEBOUNCE_CNT  stable cycles needed to accept a press or a release (>= 2)
//   REPEAT_CNT    held-key repeat period (only with KEYPAD_AUTOREPEAT_EN)
// Ports:
//   clk        in   1  system clock
//   rst        in   1  synchronous active-high reset
//   row_sense  in   4  keypad rows, active-low, asynchronous to clk
//   col_drive  out  4  column drive, active-low one-hot
//   key_code   out  4  last accepted key, 4*row + col
//   key_valid  out  1  one-cycle strobe, key_code valid in the same cycle
//   key_held   out  1  high while the accepted key remains pressed
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 1000000,
  parameter int REPEAT_CNT   = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_sense,
  output logic [3:0] col_drive,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV) + 1;
  localparam int DEB_W = $clog2(DEBOUNCE_CNT) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CNT) + 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

  logic [REP_W-1:0] rep_cnt;
`endif

  logic [3:0]       rs;
  logic [1:0]       state;
  logic [1:0]       col;
  logic [1:0]       next_col;
  logic [DIV_W-1:0] div_cnt;
  logic [DEB_W-1:0] deb_cnt;
  kp_key_t          cap_key;
  logic             row_low;

  sync_2ff #(
    .WIDTH(4)
  ) u_row_sync (
    .clk(clk),
    .rst(rst),
    .d  (row_sense),
    .q  (rs)
  );

  assign next_col = col + 2'd1;

  // Only the captured row matters once a key is being tracked; the column
  // stays frozen, so other keys cannot disturb this bit.
  assign row_low = ~rs[cap_key.row];

  // The compare values are the limit minus one: the counter is checked
  // before it would be incremented, so the action lands exactly
  // DEBOUNCE_CNT (or SCAN_DIV) cycles after counting started.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= KP_SCAN;
      col       <= 2'd0;
      col_drive <= KP_COL_IDLE;
      div_cnt   <= '0;
      deb_cnt   <= '0;
      cap_key   <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= 1'b0;

      case (state)
        KP_SCAN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (rs != 4'b1111) begin
              cap_key <= '{row: kp_lowest_low(rs), col: col};
              deb_cnt <= '0;
              state   <= KP_DEBOUNCE;
            end else begin
              col       <= next_col;
              col_drive <= kp_col_drive(next_col);
            end
          end else begin
            div_cnt <= div_cnt + DIV_ONE;
          end
        end

        KP_DEBOUNCE: begin
          if (row_low) begin
            if (deb_cnt == DEB_LAST) begin
              key_code  <= cap_key;
              key_valid <= 1'b1;
              deb_cnt   <= '0;
              state     <= KP_HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt   <= '0;
`endif
            end else begin
              deb_cnt <= deb_cnt + DEB_ONE;
            end
          end else begin
            // A bounce drops the capture; the next column gets the next look.
            col       <= next_col;
            col_drive <= kp_col_drive(next_col);
            div_cnt   <= '0;
            deb_cnt   <= '0;
            state     <= KP_SCAN;
          end
        end

        KP_HELD: begin
          key_held <= 1'b1;
          if (!row_low) begin
            if (deb_cnt == DEB_LAST) begin
              key_held  <= 1'b0;
              col       <= next_col;
              col_drive <= kp_col_drive(next_col);
              div_cnt   <= '0;
              deb_cnt   <= '0;
              state     <= KP_SCAN;
            end else begin
              deb_cnt <= deb_cnt + DEB_ONE;
            end
          end else begin
            deb_cnt <= '0;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          // Repeats keep running during the release window; key_code is
          // unchanged so a late repeat still reports the same key.
          if (rep_cnt == REP_LAST) begin
            key_valid <= 1'b1;
            rep_cnt   <= '0;
          end else begin
            rep_cnt <= rep_cnt + REP_ONE;
          end
`endif
        end

        default: begin
          state <= KP_SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Randomized scoreboard bench for keypad_scanner with SCAN_DIV=4,
// DEBOUNCE_CNT=8, REPEAT_CNT=32. A keypad model turns a set of pressed keys
// into row_sense from col_drive. Stimulus pushes expected strobes (code and,
// where the rules fix it, the cycle) into a queue; a monitor pops and
// compares on every key_valid. Honours KEYPAD_AUTOREPEAT_EN for the repeat
// scenario.
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;
  localparam int REPEAT_CNT   = 32;
  localparam int SYNC_LAT     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_sense;
  logic [3:0]  col_drive;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = 16'h0000;

  int cyc         = 0;
  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    int code;
    int at;
  } exp_t;

  exp_t exp_q[$];

  keypad_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_CNT  (REPEAT_CNT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_sense(row_sense),
    .col_drive(col_drive),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Physical keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_sense = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[4*r+c] && !col_drive[c]) row_sense[r] = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // ---------------- reference model helpers ----------------
  function automatic int colPattern(input int c);
    logic [3:0] v;
    v = 4'b1111;
    v[c] = 1'b0;
    return int'(v);
  endfunction

  function automatic int lowestRow(input int mask);
    for (int r = 0; r < 4; r++) if (mask[r]) return r;
    return 0;
  endfunction

  // A key held since reset is first seen at the end of its column's period.
  function automatic int pressLatency(input int c);
    return (c + 1) * SCAN_DIV + DEBOUNCE_CNT;
  endfunction

  function automatic logic [15:0] keysInColumn(input int mask, input int c);
    logic [15:0] k;
    k = 16'h0000;
    for (int r = 0; r < 4; r++) if (mask[r]) k[4*r+c] = 1'b1;
    return k;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (key_valid) begin
      if (rst) begin
        checkOutput("strobe_in_reset", 1, 0);
      end else if (exp_q.size() == 0) begin
        checkOutput("unexpected_strobe_code", int'(key_code), -1);
      end else begin
        e = exp_q.pop_front();
        checkOutput("strobe_code", int'(key_code), e.code);
        if (e.at >= 0) checkOutput("strobe_cycle", cyc, e.at);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] keys);
    pressed = keys;
  endtask

  task automatic doReset(input logic [15:0] keys, output int r0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(keys);
    @(negedge clk);
    checkOutput("reset_col_drive", int'(col_drive), 14);
    checkOutput("reset_key_code", int'(key_code), 0);
    checkOutput("reset_key_valid", int'(key_valid), 0);
    checkOutput("reset_key_held", int'(key_held), 0);
    @(negedge clk);
    rst = 1'b0;
    r0 = cyc;
  endtask

  task automatic waitStrobe();
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (key_valid) return;
    end
    checkOutput("strobe_timeout", 0, 1);
  endtask

  // Called on the strobe cycle; holds briefly, then releases and checks
  // that key_held falls SYNC_LAT + DEBOUNCE_CNT cycles later.
  task automatic releaseCheck(input logic [15:0] extra, input logic [15:0] keep);
    checkOutput("held_before", int'(key_held), 0);
    tick(1);
    checkOutput("held_rise", int'(key_held), 1);
    applyStimulus(pressed | extra);
    tick(4);
    applyStimulus(keep);
    tick(SYNC_LAT + DEBOUNCE_CNT - 1);
    checkOutput("held_during_release", int'(key_held), 1);
    tick(1);
    checkOutput("held_fall", int'(key_held), 0);
  endtask

  task automatic pressFromReset(input int mask, input int c);
    int r0;
    doReset(keysInColumn(mask, c), r0);
    exp_q.push_back('{code: 4*lowestRow(mask) + c, at: r0 + pressLatency(c)});
    waitStrobe();
    releaseCheck(16'h0000, 16'h0000);
    tick(5);
  endtask

  task automatic bounceFromReset(input int r, input int c, input int k);
    int r0;
    int target;
    doReset(keysInColumn(1 << r, c), r0);
    target = r0 + (c + 1) * SCAN_DIV + k;
    while (cyc < target) @(negedge clk);
    applyStimulus(16'h0000);
    tick(SYNC_LAT);
    checkOutput("bounce_frozen", int'(col_drive), colPattern(c));
    tick(1);
    checkOutput("bounce_resume", int'(col_drive), colPattern((c + 1) % 4));
    tick(20);
  endtask

  task automatic freePress();
    int k;
    int other;
    k = $urandom_range(0, 15);
    other = (k + $urandom_range(1, 15)) % 16;
    tick($urandom_range(0, 7));
    exp_q.push_back('{code: k, at: -1});
    applyStimulus(16'h0001 << k);
    waitStrobe();
    releaseCheck(16'h0001 << other, 16'h0000);
    tick(5);
  endtask

  initial begin : stim
    int r0;
    int target;
    int mode;
    $display("[TB] keypad_scanner bench start");

    // Idle scan rotation after reset.
    doReset(16'h0000, r0);
    for (int i = 0; i < 24; i++) begin
      checkOutput("idle_col_drive", int'(col_drive), colPattern(((cyc - r0) / SCAN_DIV) % 4));
      tick(1);
    end

    // Key 9 (row 2, column 1).
    pressFromReset(4'b0100, 1);

    // Bounce on row 0.
    bounceFromReset(0, 2, 3);

    // Rows 1 and 3 on column 3: key 7 wins; key 15 is reported only after
    // key 7's release completes.
    doReset(keysInColumn(4'b1010, 3), r0);
    exp_q.push_back('{code: 7, at: r0 + pressLatency(3)});
    waitStrobe();
    exp_q.push_back('{code: 15, at: -1});
    releaseCheck(16'h0000, 16'h8000);
    waitStrobe();
    releaseCheck(16'h0000, 16'h0000);
    tick(5);

    // Reset in the middle of debouncing key 9, row held through reset.
    doReset(keysInColumn(4'b0100, 1), r0);
    target = r0 + 2 * SCAN_DIV + 3;
    while (cyc < target) @(negedge clk);
    doReset(keysInColumn(4'b0100, 1), r0);
    exp_q.push_back('{code: 9, at: r0 + pressLatency(1)});
    waitStrobe();
    releaseCheck(16'h0000, 16'h0000);
    tick(5);

    // Key 0 held for 100 cycles after its strobe.
    doReset(16'h0001, r0);
    exp_q.push_back('{code: 0, at: r0 + pressLatency(0)});
`ifdef KEYPAD_AUTOREPEAT_EN
    for (int n = 1; n <= 3; n++)
      exp_q.push_back('{code: 0, at: r0 + pressLatency(0) + n * REPEAT_CNT});
`endif
    waitStrobe();
    target = r0 + pressLatency(0) + 100;
    while (cyc < target) @(negedge clk);
    checkOutput("long_hold_held", int'(key_held), 1);
    applyStimulus(16'h0000);
    tick(SYNC_LAT + DEBOUNCE_CNT);
    checkOutput("long_hold_fall", int'(key_held), 0);
    tick(5);

    // Randomized mix of scenarios.
    for (int n = 0; n < 16; n++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: pressFromReset(1 << $urandom_range(0, 3), $urandom_range(0, 3));
        1: bounceFromReset($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
        2: pressFromReset($urandom_range(1, 15), $urandom_range(0, 3));
        default: freePress();
      endcase
    end

    tick(10);
    checkOutput("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad and turns key presses into 4-bit key codes with a one-cycle valid strobe. Like the seven-segment driver, it is a time-multiplexed board I/O block, but it runs in the input direction: it drives the columns one at a time, reads the rows back, debounces them and reports the key. It sits at the board I/O boundary and feeds key codes into the RV32 system, for example as operand entry or for memory-mapped input.

## Interface
- SCAN_DIV, 50000: clock cycles each column stays driven; must be ≥ 4.
- DEBOUNCE_CNT, 1000000: consecutive stable cycles required to accept a press or a release; must be ≥ 2.
- REPEAT_CNT, 50000000: held-key repeat period in cycles; used only when `KEYPAD_AUTOREPEAT_EN` is defined.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- row_sense  in  4  keypad rows; active-low, pulled up on the board, asynchronous to clk.
- col_drive  out  4  column drive; active-low one-hot.
- key_code  out  4  code of the last accepted key, equal to 4*row + col.
- key_valid  out  1  one-cycle strobe; key_code is valid in the same cycle.
- key_held  out  1  high while the accepted key remains pressed.

## Operation
- row_sense passes through a 2-flop synchronizer, giving `rs`. The synchronizer flops reset to 4'b1111.
- Reset values:
  - col_drive = 4'b1110
  - key_code = 0, key_valid = 0, key_held = 0
  - FSM in SCAN, all counters 0
- State SCAN:
  - The column index advances 0→1→2→3→0 every SCAN_DIV cycles; col_drive = ~(1 << col).
  - `rs` is sampled in the last cycle of each column period.
  - If any bit of the sample is 0, the lowest-index low row is captured with the current column, col_drive is frozen, the debounce counter is cleared, and the FSM goes to DEBOUNCE.
- State DEBOUNCE:
  - Each cycle the captured row bit of `rs` is 0, the counter increments.
  - When the counter reaches DEBOUNCE_CNT: key_code <= {row, col}, key_valid pulses for one cycle, and the FSM goes to HELD.
  - Any cycle with the captured row bit at 1: back to SCAN, and scanning resumes at the next column.
- State HELD:
  - key_held = 1 and col_drive stays frozen.
  - The release counter increments while the captured row bit is 1 and clears to 0 when it is 0.
  - When the release counter reaches DEBOUNCE_CNT: key_held falls and the FSM goes to SCAN, resuming at the next column.
- Multiple keys: only the first captured key is reported. Other rows and columns are ignored until it is released; no rollover.
- key_code holds its value between strobes and changes only on a key_valid cycle.
- Counters are sized with $clog2 of their limit plus 1 and never wrap. The scan-divider counter wraps to 0 at SCAN_DIV-1.
- rst in any state returns every output to its reset value on the next edge. A press in progress is discarded, and key_valid is never emitted in the reset cycle.

## Timing
- Synchronizer latency is 2 cycles from a row_sense edge to `rs`.
- Press to strobe: key_valid asserts exactly DEBOUNCE_CNT cycles after entering DEBOUNCE, if every sample in that window was low.
- key_held rises in the cycle after key_valid and falls DEBOUNCE_CNT cycles after the first stable-high cycle.
- At most one key_valid per press (auto-repeat off).
- A bounce during DEBOUNCE costs one full column rescan, up to 4*SCAN_DIV cycles, before the key can be re-captured.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - In HELD, a repeat counter counts cycles.
  - At REPEAT_CNT it re-pulses key_valid with the same key_code and restarts from 0.
  - The repeat counter clears on entry to HELD, so the first repeat comes REPEAT_CNT cycles after the first strobe.
- KEYPAD_AUTOREPEAT_EN undefined: no repeat counter is built, REPEAT_CNT is ignored, and there is exactly one strobe per press.

## Structure
- The shared defines header holds:
  - FSM state encodings `KP_SCAN`, `KP_DEBOUNCE`, `KP_HELD` (2 bits).
  - `KP_COL_IDLE` = 4'b1110.
- Sub-module `sync_2ff`: parameterized width, 2-flop synchronizer with reset value all-ones, instantiated with width 4 on row_sense.
- All other logic stays in one module: FSM, scan divider, debounce/release counter, and the optional repeat counter.

## Test plan
Benches run with SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CNT=32.
- Reset then idle (rows all 1) → col_drive cycles 1110, 1101, 1011, 0111, one step every 4 cycles; key_valid never rises.
- Hold row 2 low while column 1 is driven, for 20 cycles → exactly one key_valid with key_code = 9; key_held = 1 until release.
- Row 0 low for 5 cycles, then high (bounce) → no key_valid; scanning resumes at the next column.
- Rows 1 and 3 both low on column 3 → key_code = 7; row 3 ignored until release completes.
- Assert rst mid-DEBOUNCE, then release rst with the row still low → outputs return to reset values, then a fresh press yields one strobe.
- With `KEYPAD_AUTOREPEAT_EN`, hold key 0 for 100 cycles after its strobe → strobes at +32, +64 and +96 cycles, all with key_code = 0.
